// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory fetch controller and the imem it drives.
package imem_pkg;

  localparam int IMEM_DEPTH    = 400;
  localparam int IMEM_WORD_W   = 32;
  localparam int IMEM_RESET_PC = 0;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_unit.sv
// Program counter for the RUN phase: next-pc selection, pc register and range check.
import imem_pkg::*;

module fetch_pc_unit #(
  parameter int DEPTH    = IMEM_DEPTH,
  parameter int WORD_W   = IMEM_WORD_W,
  parameter int RESET_PC = IMEM_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_target,
  input  logic              halt_req,
  output logic [WORD_W-1:0] pc,
  output logic              oob
);

  localparam logic [WORD_W-1:0] DEPTH_W = WORD_W'(DEPTH);
  localparam logic [WORD_W-1:0] RESET_W = WORD_W'(RESET_PC);

  logic [WORD_W-1:0] pc_inc;
  logic [WORD_W-1:0] pc_next;
  logic              target_oob;
  logic              seq_oob;

  // A halt request wins outright, so an illegal redirect in the same cycle is not a fault.
  always_comb begin
    pc_inc     = pc + WORD_W'(1);
    target_oob = (redirect_target >= DEPTH_W);
    seq_oob    = (pc_inc >= DEPTH_W);
    oob        = 1'b0;
    if (run && !halt_req) begin
      if (redirect_valid) begin
        oob = target_oob;
      end else if (!stall) begin
        oob = seq_oob;
      end
    end
  end

  always_comb begin
    pc_next = pc;
    if (run && !halt_req && !oob) begin
      if (redirect_valid) begin
        pc_next = redirect_target;
      end else if (!stall) begin
        pc_next = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_W;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Boot-loads program words into imem, then hands the memory to the core as a fetch port.
import imem_pkg::*;

module imem_fetch_ctrl #(
  parameter int DEPTH    = IMEM_DEPTH,
  parameter int WORD_W   = IMEM_WORD_W,
  parameter int RESET_PC = IMEM_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [WORD_W-1:0] load_data,
  input  logic              load_done,
  output logic              load_ready,
  output logic [WORD_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              imem_we,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_target,
  input  logic              halt_req,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  output logic [WORD_W-1:0] fetch_pc,
  output logic [WORD_W-1:0] load_count,
  output logic              fault
);

  localparam logic [WORD_W-1:0] DEPTH_W = WORD_W'(DEPTH);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [WORD_W-1:0] pc;
  logic              oob;
  logic              room;
  logic              handshake;
  logic              last_word;

  fetch_pc_unit #(
    .DEPTH    (DEPTH),
    .WORD_W   (WORD_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk             (clk),
    .rst_n           (rst_n),
    .run             (state == RUN),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .pc              (pc),
    .oob             (oob)
  );

  always_comb begin
    room      = (load_count < DEPTH_W);
    handshake = (state == LOAD) && load_valid && room;
    last_word = handshake && ((load_count + WORD_W'(1)) == DEPTH_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      BOOT: state_next = LOAD;
      LOAD: if (load_done || last_word) state_next = RUN;
      RUN:  if (halt_req || oob) state_next = HALT;
      HALT: state_next = HALT;
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_count <= '0;
      fault      <= 1'b0;
    end else begin
      if (handshake) begin
        load_count <= load_count + WORD_W'(1);
      end
      if ((state == RUN) && oob) begin
        fault <= 1'b1;
      end
    end
  end

  // Single imem port: the loader owns it in LOAD, the pc owns it afterwards.
  always_comb begin
    load_ready  = 1'b0;
    imem_addr   = '0;
    imem_wdata  = '0;
    imem_we     = 1'b0;
    instr       = '0;
    instr_valid = 1'b0;
    fetch_pc    = '0;
    unique case (state)
      BOOT: begin
      end
      LOAD: begin
        load_ready = room;
        imem_addr  = load_count;
        fetch_pc   = pc;
        if (handshake) begin
          imem_we    = 1'b1;
          imem_wdata = load_data;
        end
      end
      RUN: begin
        imem_addr   = pc;
        instr       = imem_rdata;
        instr_valid = 1'b1;
        fetch_pc    = pc;
      end
      HALT: begin
        imem_addr = pc;
        fetch_pc  = pc;
      end
      default: begin
      end
    endcase
  end

endmodule
